// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt merger for the MCU: per-source sync/pending lanes, mask, one-at-a-time FSM.
// Define INTC_ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index priority.

module intc_lane (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  // [0],[1] are the synchroniser, [2] is the delayed copy for edge detection
  logic [2:0] sync_pipe;
  logic       rise;

  assign rise = sync_pipe[1] & ~sync_pipe[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      pend      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], irq};
      if (rise)     pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end
endmodule

module interrupt_controller #(
  parameter int         NUM_IRQ      = 8,
  parameter logic [7:0] MASK_PORT_ID = 8'h30,
  parameter logic [7:0] EOI_PORT_ID  = 8'h31
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               INT_ACK,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  output logic               INTERRUPT,
  output logic [7:0]         INT_ID,
  output logic [NUM_IRQ-1:0] PEND_OUT
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] mask, pend, elig, pend_clr;
  logic [2:0]         act_id, win_id, rr_start;
  logic               valid, win_any, mask_wr, eoi_wr, ack;

  assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT_ID);
  assign eoi_wr  = IO_STRB && (PORT_ID == EOI_PORT_ID);
  assign ack     = (state == ASSERT) && INT_ACK;
  assign elig    = pend & mask;

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      pend_clr[i] = ack && (act_id == 3'(i));
  end

  intc_lane u_lane [NUM_IRQ-1:0] (
    .clk  (CLK),
    .rst  (RESET),
    .irq  (IRQ),
    .clr  (pend_clr),
    .pend (pend)
  );

`ifdef INTC_ROUND_ROBIN_EN
  logic [2:0] last;

  always_ff @(posedge CLK) begin
    if (RESET)    last <= 3'(NUM_IRQ-1);
    else if (ack) last <= act_id;
  end

  assign rr_start = (last == 3'(NUM_IRQ-1)) ? 3'd0 : last + 3'd1;
`else
  assign rr_start = 3'd0;
`endif

  // Search [rr_start..N-1] first, then wrap to [0..rr_start-1]
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (!win_any && elig[i] && (3'(i) >= rr_start)) begin
        win_any = 1'b1;
        win_id  = 3'(i);
      end
    for (int i = 0; i < NUM_IRQ; i++)
      if (!win_any && elig[i] && (3'(i) < rr_start)) begin
        win_any = 1'b1;
        win_id  = 3'(i);
      end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any) state_nxt = ASSERT;
      ASSERT:  if (INT_ACK) state_nxt = SERVICE;
      SERVICE: if (eoi_wr)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      mask   <= '0;
      act_id <= '0;
      valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mask_wr) mask <= OUT_PORT[NUM_IRQ-1:0];
      if (state == IDLE && win_any) begin
        act_id <= win_id;
        valid  <= 1'b1;
      end else if (state == SERVICE && eoi_wr) begin
        act_id <= '0;
        valid  <= 1'b0;
      end
    end
  end

  assign INTERRUPT = (state == ASSERT);
  assign INT_ID    = {valid, 4'b0000, act_id};
  assign PEND_OUT  = pend;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, masking, priority, no-nesting, set-wins, reset.
// Expectations follow INTC_ROUND_ROBIN_EN when the macro is defined for the build.

module tb_interrupt_controller;
  logic       CLK = 1'b0;
  logic       RESET, INT_ACK, IO_STRB, INTERRUPT;
  logic [7:0] IRQ, PORT_ID, OUT_PORT, INT_ID, PEND_OUT;

  int n_chk  = 0;
  int n_pass = 0;

  interrupt_controller dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .INT_ACK(INT_ACK), .IO_STRB(IO_STRB),
    .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .INTERRUPT(INTERRUPT), .INT_ID(INT_ID),
    .PEND_OUT(PEND_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic port_wr(input logic [7:0] id, input logic [7:0] data);
    IO_STRB = 1'b1; PORT_ID = id; OUT_PORT = data;
    tick();
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic do_ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (!INTERRUPT && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(INTERRUPT), 32'd1);
  endtask

  task automatic pulse(input logic [7:0] v);
    IRQ = v;
    tick();
    IRQ = 8'h00;
  endtask

  logic [7:0] first_id, second_id, after_first;

  initial begin
`ifdef INTC_ROUND_ROBIN_EN
    first_id = 8'h86; second_id = 8'h81; after_first = 8'h02;
`else
    first_id = 8'h81; second_id = 8'h86; after_first = 8'h40;
`endif
    RESET = 1'b1; IRQ = 8'h00; INT_ACK = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    ticks(2);
    RESET = 1'b0;
    chk("rst_int", 32'(INTERRUPT), 32'd0);
    chk("rst_id", 32'(INT_ID), 32'h00);
    chk("rst_pend", 32'(PEND_OUT), 32'h00);

    // T1 single source, exact latency
    port_wr(8'h30, 8'h04);
    IRQ = 8'h04;
    tick();                 // edge k
    IRQ = 8'h00;
    ticks(2);               // edge k+2
    chk("t1_int_k2", 32'(INTERRUPT), 32'd0);
    chk("t1_pend_k2", 32'(PEND_OUT), 32'h04);
    tick();                 // edge k+3
    chk("t1_int_k3", 32'(INTERRUPT), 32'd1);
    chk("t1_id_assert", 32'(INT_ID), 32'h82);
    do_ack();
    chk("t1_int_ack", 32'(INTERRUPT), 32'd0);
    chk("t1_id_ack", 32'(INT_ID), 32'h82);
    chk("t1_pend_ack", 32'(PEND_OUT), 32'h00);
    port_wr(8'h31, 8'hA5);
    chk("t1_id_eoi", 32'(INT_ID), 32'h00);
    chk("t1_int_eoi", 32'(INTERRUPT), 32'd0);

    // T2 masked source latches, unmask releases it
    port_wr(8'h30, 8'h00);
    pulse(8'h20);
    ticks(4);
    chk("t2_pend_masked", 32'(PEND_OUT), 32'h20);
    chk("t2_int_masked", 32'(INTERRUPT), 32'd0);
    port_wr(8'h30, 8'h20);
    chk("t2_int_w", 32'(INTERRUPT), 32'd0);
    tick();
    chk("t2_int_w1", 32'(INTERRUPT), 32'd1);
    chk("t2_id", 32'(INT_ID), 32'h85);
    do_ack();
    port_wr(8'h31, 8'h00);
    chk("t2_pend_done", 32'(PEND_OUT), 32'h00);

    // T3 simultaneous sources 1 and 6
    port_wr(8'h30, 8'hFF);
    pulse(8'h42);
    wait_int("t3_wait1");
    chk("t3_id1", 32'(INT_ID), 32'(first_id));
    chk("t3_pend_both", 32'(PEND_OUT), 32'h42);
    do_ack();
    chk("t3_pend_after1", 32'(PEND_OUT), 32'(after_first));
    port_wr(8'h31, 8'h00);
    wait_int("t3_wait2");
    chk("t3_id2", 32'(INT_ID), 32'(second_id));
    do_ack();
    port_wr(8'h31, 8'h00);
    chk("t3_pend_done", 32'(PEND_OUT), 32'h00);

    // T4 held level gives one event; no nesting before EOI
    IRQ = 8'h01;
    wait_int("t4_wait");
    chk("t4_id", 32'(INT_ID), 32'h80);
    do_ack();
    ticks(5);
    chk("t4_int_level", 32'(INTERRUPT), 32'd0);
    chk("t4_pend_level", 32'(PEND_OUT), 32'h00);
    IRQ = 8'h00;
    ticks(3);
    IRQ = 8'h01;
    ticks(4);
    chk("t4_pend_repulse", 32'(PEND_OUT), 32'h01);
    chk("t4_int_noeoi", 32'(INTERRUPT), 32'd0);
    port_wr(8'h31, 8'h00);
    tick();
    chk("t4_int_after_eoi", 32'(INTERRUPT), 32'd1);
    chk("t4_id2", 32'(INT_ID), 32'h80);
    do_ack();
    port_wr(8'h31, 8'h00);
    IRQ = 8'h00;
    ticks(3);

    // T5 new edge lands on the acknowledging cycle
    pulse(8'h08);
    wait_int("t5_wait");
    chk("t5_id", 32'(INT_ID), 32'h83);
    IRQ = 8'h08;
    tick();                 // edge k
    tick();                 // edge k+1: edge pulse now visible
    INT_ACK = 1'b1;
    tick();                 // edge k+2: set and clear together
    INT_ACK = 1'b0;
    IRQ = 8'h00;
    chk("t5_pend_setwins", 32'(PEND_OUT), 32'h08);
    chk("t5_int_service", 32'(INTERRUPT), 32'd0);
    port_wr(8'h31, 8'h00);
    tick();
    chk("t5_rereq", 32'(INTERRUPT), 32'd1);
    chk("t5_id2", 32'(INT_ID), 32'h83);
    do_ack();
    port_wr(8'h31, 8'h00);

    // T6 reset while asserting
    pulse(8'h10);
    wait_int("t6_wait");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6_int", 32'(INTERRUPT), 32'd0);
    chk("t6_id", 32'(INT_ID), 32'h00);
    chk("t6_pend", 32'(PEND_OUT), 32'h00);
    pulse(8'h10);
    ticks(5);
    chk("t6_pend_masked", 32'(PEND_OUT), 32'h10);
    chk("t6_int_masked", 32'(INTERRUPT), 32'd0);
    do_ack();
    chk("t6_spurious_pend", 32'(PEND_OUT), 32'h10);
    chk("t6_spurious_int", 32'(INTERRUPT), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
